// File: rtl/inst_cache_pkg.sv
// Shared types for the instruction-cache slice: bus records, controller states
// and the address-field widths for the default geometry.
package meminf;

   localparam int LINE_COUNT_DEF     = 64;
   localparam int WORDS_PER_LINE_DEF = 4;
   localparam int ERRTY_W            = 2;

   localparam int OFFSET_W = $clog2(WORDS_PER_LINE_DEF);
   localparam int INDEX_W  = $clog2(LINE_COUNT_DEF);
   localparam int TAG_W    = 30 - OFFSET_W - INDEX_W;

   // The ready handshake travels on its own port next to each request record.
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } CacheReq;

   typedef struct packed {
      logic               valid;
      logic [31:0]        rdata;
      logic               error;
      logic [ERRTY_W-1:0] errty;
   } CacheResp;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL_WAIT,
      RESPOND
   } ICacheState;

endpackage

// File: rtl/inst_cache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache:
// one synchronous write port, asynchronous read of the whole line by index.
module icache_array
   import meminf::*;
#(
   parameter int LINE_COUNT     = LINE_COUNT_DEF,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
   parameter int INDEX_W        = $clog2(LINE_COUNT),
   parameter int OFFSET_W       = $clog2(WORDS_PER_LINE),
   parameter int TAG_W          = 30 - INDEX_W - OFFSET_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic [INDEX_W-1:0]               idx,
   input  logic                             data_we,
   input  logic [OFFSET_W-1:0]              w_off,
   input  logic [31:0]                      w_data,
   input  logic                             tag_we,
   input  logic                             tag_valid,
   input  logic [TAG_W-1:0]                 w_tag,
   output logic                             rd_valid,
   output logic [TAG_W-1:0]                 rd_tag,
   output logic [WORDS_PER_LINE-1:0][31:0]  rd_line
);

   logic [LINE_COUNT-1:0] valid_reg;
   logic [TAG_W-1:0]      tag_mem [LINE_COUNT];

   // Flush dominates any same-cycle valid-bit write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
      end else if (flush) begin
         valid_reg <= '0;
      end else if (tag_we) begin
         valid_reg[idx] <= tag_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[idx] <= w_tag;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
         logic [31:0] bank_mem [LINE_COUNT];

         always_ff @(posedge clk) begin
            if (data_we && (w_off == OFFSET_W'(gi))) begin
               bank_mem[idx] <= w_data;
            end
         end

         assign rd_line[gi] = bank_mem[idx];
      end
   endgenerate

   assign rd_valid = valid_reg[idx];
   assign rd_tag   = tag_mem[idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with in-order line refill,
// one outstanding memory read, and a single-cycle response pulse per request.
module inst_cache
   import meminf::*;
#(
   parameter int LINE_COUNT     = LINE_COUNT_DEF,
   parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
   input  logic     clk,
   input  logic     rst_n,
   input  CacheReq  creq,
   output logic     creq_ready,
   output CacheResp cresp,
   output CacheReq  mreq,
   input  logic     mreq_ready,
   input  CacheResp mresp,
   input  logic     flush
);

   localparam int OW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(LINE_COUNT);
   localparam int TW = 30 - OW - IW;

   ICacheState         state_reg, state_next;
   logic [31:0]        addr_reg;
   logic [OW-1:0]      cnt_reg;
   logic               err_reg;
   logic [ERRTY_W-1:0] errty_reg;
   logic               flushed_reg;

   logic [OW-1:0]      req_off;
   logic [IW-1:0]      req_idx;
   logic [TW-1:0]      req_tag;

   logic                            rd_valid;
   logic [TW-1:0]                   rd_tag;
   logic [WORDS_PER_LINE-1:0][31:0] rd_line;
   logic [31:0]                     rd_word;
   logic                            hit;
   logic                            last_word;

   logic accept;
   logic data_we;
   logic tag_we;
   logic tag_valid;

   logic unused_bits;

   assign req_off   = addr_reg[OW+1:2];
   assign req_idx   = addr_reg[OW+IW+1:OW+2];
   assign req_tag   = addr_reg[31:OW+IW+2];
   assign rd_word   = rd_line[req_off];
   assign hit       = rd_valid && (rd_tag == req_tag);
   assign last_word = (cnt_reg == OW'(WORDS_PER_LINE - 1));

   // Write data, write mask and byte offset have no meaning for a fetch-only cache.
   assign unused_bits = ^{creq.wen, creq.wdata, creq.wmask, creq.addr[1:0]};

   icache_array #(
      .LINE_COUNT     (LINE_COUNT),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .INDEX_W        (IW),
      .OFFSET_W       (OW),
      .TAG_W          (TW)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .idx       (req_idx),
      .data_we   (data_we),
      .w_off     (cnt_reg),
      .w_data    (mresp.rdata),
      .tag_we    (tag_we),
      .tag_valid (tag_valid),
      .w_tag     (req_tag),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_line   (rd_line)
   );

   always_comb begin
      state_next = state_reg;
      creq_ready = 1'b0;
      cresp      = '0;
      mreq       = '0;
      accept     = 1'b0;
      data_we    = 1'b0;
      tag_we     = 1'b0;
      tag_valid  = 1'b0;

      case (state_reg)
         IDLE: begin
            creq_ready = 1'b1;
            if (creq.valid) begin
               accept     = 1'b1;
               state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cresp.valid = 1'b1;
               cresp.rdata = rd_word;
               creq_ready  = 1'b1;
               if (creq.valid) begin
                  accept     = 1'b1;
                  state_next = LOOKUP;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               // The refill overwrites this line word by word, so drop it now.
               tag_we     = 1'b1;
               tag_valid  = 1'b0;
               state_next = REFILL_REQ;
            end
         end
         REFILL_REQ: begin
            mreq.valid = 1'b1;
            mreq.addr  = {req_tag, req_idx, cnt_reg, 2'b00};
            if (mreq_ready) begin
               state_next = REFILL_WAIT;
            end
         end
         REFILL_WAIT: begin
            if (mresp.valid) begin
               data_we    = 1'b1;
               state_next = last_word ? RESPOND : REFILL_REQ;
            end
         end
         RESPOND: begin
            cresp.valid = 1'b1;
            if (err_reg) begin
               cresp.error = 1'b1;
               cresp.errty = errty_reg;
            end else begin
               cresp.rdata = rd_word;
            end
            tag_we     = !err_reg && !flushed_reg && !flush;
            tag_valid  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         cnt_reg     <= '0;
         err_reg     <= 1'b0;
         errty_reg   <= '0;
         flushed_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg <= creq.addr;
         end
         if ((state_reg == LOOKUP) && !hit) begin
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            errty_reg   <= '0;
            flushed_reg <= 1'b0;
         end
         if ((state_reg == REFILL_WAIT) && mresp.valid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (mresp.error && !err_reg) begin
               err_reg   <= 1'b1;
               errty_reg <= mresp.errty;
            end
         end
         if (flush && ((state_reg == REFILL_REQ) || (state_reg == REFILL_WAIT) ||
                       (state_reg == RESPOND))) begin
            flushed_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed vector table, hand-written back-to-back and
// reset sequences, then random traffic checked against a line-level model.
module tb_inst_cache;
   import meminf::*;

   localparam int LINES = 64;
   localparam int WPL   = 4;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   logic     flush = 1'b0;
   logic     creq_ready;
   logic     mreq_ready = 1'b0;
   CacheReq  creq = '0;
   CacheReq  mreq;
   CacheResp cresp;
   CacheResp mresp = '0;

   always #5 clk = ~clk;

   inst_cache #(.LINE_COUNT(LINES), .WORDS_PER_LINE(WPL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .creq       (creq),
      .creq_ready (creq_ready),
      .cresp      (cresp),
      .mreq       (mreq),
      .mreq_ready (mreq_ready),
      .mresp      (mresp),
      .flush      (flush)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // Backing memory contents and error injection point.
   logic [31:0] err_addr = 32'hFFFF_FFFF;
   logic [1:0]  err_ty   = 2'd2;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] r;
      case (a)
         32'h100: r = 32'h11;
         32'h104: r = 32'h22;
         32'h108: r = 32'h33;
         32'h10C: r = 32'h44;
         default: r = {a[15:0] ^ 16'h5A5A, a[15:0]};
      endcase
      return r;
   endfunction

   // Memory responder: random ready and latency when mem_rand is set.
   logic [31:0] mreq_log[$];
   int          mreq_valid_cycles = 0;
   int          wen_bad = 0;
   bit          mem_rand = 1'b0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          pend_dly = 0;

   initial begin
      forever begin
         @(negedge clk);
         mresp = '0;
         if (pend) begin
            if (pend_dly == 0) begin
               mresp.valid = 1'b1;
               mresp.rdata = mem_word(pend_addr);
               if (pend_addr == err_addr) begin
                  mresp.error = 1'b1;
                  mresp.errty = err_ty;
               end
               pend = 1'b0;
            end else begin
               pend_dly--;
            end
         end
         mreq_ready = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (mreq.valid) mreq_valid_cycles++;
         if (mreq.valid && mreq_ready && rst_n) begin
            mreq_log.push_back(mreq.addr);
            if (mreq.wen) wen_bad++;
            pend      = 1'b1;
            pend_addr = mreq.addr;
            pend_dly  = mem_rand ? int'($urandom_range(0, 2)) : 0;
         end
      end
   end

   // Reference model: which memory line each cache slot holds.
   bit          mvalid [LINES];
   logic [31:0] mtag   [LINES];

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk); #1;
      flush = 1'b1;
      @(negedge clk); #1;
      flush = 1'b0;
      model_clear();
   endtask

   task automatic run_req(input logic [31:0] a, input int flush_at,
                          output logic [31:0] rd, output bit er, output logic [1:0] et,
                          output int lat, output bit ok, output bit did_fl);
      int k;
      ok = 1'b0; did_fl = 1'b0; rd = '0; er = 1'b0; et = '0; lat = 0;
      @(negedge clk); #1;
      flush = 1'b0;
      mreq_log.delete();
      creq.valid = 1'b1;
      creq.addr  = a;
      creq.wen   = 1'($urandom);
      creq.wdata = $urandom;
      creq.wmask = 4'($urandom);
      k = 0;
      while (!creq_ready && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      if (!creq_ready) begin
         creq.valid = 1'b0;
         return;
      end
      @(negedge clk); #1;
      creq.valid = 1'b0;
      lat = 1;
      while (lat < 500) begin
         if (flush_at >= 0 && !did_fl && mreq_log.size() == flush_at) begin
            flush  = 1'b1;
            did_fl = 1'b1;
         end else begin
            flush = 1'b0;
         end
         if (cresp.valid) begin
            rd = cresp.rdata; er = cresp.error; et = cresp.errty; ok = 1'b1;
            break;
         end
         @(negedge clk); #1;
         lat++;
      end
      if (flush) begin
         @(negedge clk); #1;
         flush = 1'b0;
      end
   endtask

   // One transaction; expectations come from the table when use_tab, else the model.
   task automatic txn(input string name, input logic [31:0] a, input int flush_at,
                      input bit use_tab, input logic [31:0] t_rdata, input bit t_err,
                      input int t_ref);
      int          idx, lat, e_ref;
      logic [31:0] tg, base, e_rdata, rd;
      logic [1:0]  et;
      bit          p_hit, p_err, e_err, er, ok, did_fl;
      idx   = int'((a / (WPL * 4)) % LINES);
      tg    = a / (WPL * 4 * LINES);
      base  = a - (a % (WPL * 4));
      p_hit = mvalid[idx] && (mtag[idx] == tg);
      p_err = 1'b0;
      if (!p_hit)
         for (int w = 0; w < WPL; w++)
            if (base + 32'(4 * w) == err_addr) p_err = 1'b1;
      if (use_tab) begin
         e_rdata = t_rdata; e_err = t_err; e_ref = t_ref;
      end else begin
         e_rdata = p_err ? 32'h0 : mem_word(a - (a % 4));
         e_err   = p_err;
         e_ref   = p_hit ? 0 : WPL;
      end
      run_req(a, flush_at, rd, er, et, lat, ok, did_fl);
      $display("txn %s addr=%08h rdata=%08h err=%0d errty=%0d lat=%0d refills=%0d flush=%0d",
               name, a, rd, er, et, lat, mreq_log.size(), did_fl);
      check({name, ".resp_seen"}, 32'(ok), 32'd1);
      check({name, ".rdata"}, rd, e_rdata);
      check({name, ".error"}, 32'(er), 32'(e_err));
      if (e_err) check({name, ".errty"}, 32'(et), 32'(err_ty));
      check({name, ".refills"}, 32'(mreq_log.size()), 32'(e_ref));
      if (e_ref == 0) begin
         check({name, ".hit_latency"}, 32'(lat), 32'd1);
      end else begin
         for (int w = 0; w < WPL && w < mreq_log.size(); w++)
            check($sformatf("%s.maddr%0d", name, w), mreq_log[w], base + 32'(4 * w));
      end
      if (did_fl) model_clear();
      if (!p_hit) begin
         if (!p_err && !(did_fl && flush_at >= 1)) begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
         end else begin
            mvalid[idx] = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          flush_before;
      int          flush_at;
      logic [31:0] err_at;
      logic [31:0] rdata;
      bit          err;
      int          nref;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base_cycles;
      int k;
      bit bad;
      logic [31:0] pool [8];

      vecs[0]  = '{32'h104, 0, -1, 32'hFFFF_FFFF, 32'h22,        0, 4};
      vecs[1]  = '{32'h104, 1, -1, 32'hFFFF_FFFF, 32'h22,        0, 4};
      vecs[2]  = '{32'h504, 0, -1, 32'hFFFF_FFFF, 32'h5F5E_0504, 0, 4};
      vecs[3]  = '{32'h104, 0, -1, 32'hFFFF_FFFF, 32'h22,        0, 4};
      vecs[4]  = '{32'h104, 0, -1, 32'hFFFF_FFFF, 32'h22,        0, 0};
      vecs[5]  = '{32'h500, 0, -1, 32'h504,       32'h0,         1, 4};
      vecs[6]  = '{32'h500, 0, -1, 32'h504,       32'h0,         1, 4};
      vecs[7]  = '{32'h500, 0, -1, 32'hFFFF_FFFF, 32'h5F5A_0500, 0, 4};
      vecs[8]  = '{32'h500, 0,  0, 32'hFFFF_FFFF, 32'h5F5A_0500, 0, 0};
      vecs[9]  = '{32'h500, 0, -1, 32'hFFFF_FFFF, 32'h5F5A_0500, 0, 4};
      vecs[10] = '{32'h208, 0,  2, 32'hFFFF_FFFF, 32'h5852_0208, 0, 4};
      vecs[11] = '{32'h20C, 0, -1, 32'hFFFF_FFFF, 32'h5856_020C, 0, 4};
      vecs[12] = '{32'h200, 0, -1, 32'hFFFF_FFFF, 32'h585A_0200, 0, 0};

      model_clear();
      repeat (3) @(negedge clk);
      #1;
      check("reset.cresp_valid", 32'(cresp.valid), 32'd0);
      check("reset.mreq_valid", 32'(mreq.valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check("reset.creq_ready", 32'(creq_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         err_addr = vecs[i].err_at;
         if (vecs[i].flush_before) pulse_flush();
         txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].flush_at, 1'b1,
             vecs[i].rdata, vecs[i].err, vecs[i].nref);
         if (i == 0) begin
            // Back-to-back hits on the freshly filled line.
            @(negedge clk); #1;
            base_cycles = mreq_valid_cycles;
            creq.valid = 1'b1;
            creq.addr  = 32'h100;
            @(negedge clk); #1;
            check("b2b0.valid", 32'(cresp.valid), 32'd1);
            check("b2b0.rdata", cresp.rdata, 32'h11);
            check("b2b0.ready", 32'(creq_ready), 32'd1);
            creq.addr = 32'h108;
            @(negedge clk); #1;
            check("b2b1.valid", 32'(cresp.valid), 32'd1);
            check("b2b1.rdata", cresp.rdata, 32'h33);
            creq.addr = 32'h10C;
            @(negedge clk); #1;
            check("b2b2.valid", 32'(cresp.valid), 32'd1);
            check("b2b2.rdata", cresp.rdata, 32'h44);
            creq.valid = 1'b0;
            @(negedge clk); #1;
            check("b2b.end_valid", 32'(cresp.valid), 32'd0);
            check("b2b.no_mreq", 32'(mreq_valid_cycles - base_cycles), 32'd0);
            $display("txn b2b addrs=100,108,10C");
         end
      end

      // Reset while waiting for refill word 2 of a miss on 0x104.
      err_addr = 32'hFFFF_FFFF;
      @(negedge clk); #1;
      mreq_log.delete();
      creq.valid = 1'b1;
      creq.addr  = 32'h104;
      @(negedge clk); #1;
      creq.valid = 1'b0;
      k = 0;
      while (mreq_log.size() < 3 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      check("rstmid.reached_word2", 32'(mreq_log.size()), 32'd3);
      @(negedge clk); #1;
      rst_n = 1'b0;
      bad = 1'b0;
      repeat (3) begin
         #1;
         if (cresp.valid || mreq.valid) bad = 1'b1;
         @(negedge clk); #1;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk); #1;
         if (cresp.valid || mreq.valid) bad = 1'b1;
      end
      check("rstmid.no_output", 32'(bad), 32'd0);
      check("rstmid.ready", 32'(creq_ready), 32'd1);
      $display("txn reset_mid_refill addr=00000104");
      model_clear();
      txn("after_reset", 32'h104, -1, 1'b1, 32'h22, 1'b0, 4);

      // Random traffic over conflicting lines with random flushes and memory timing.
      mem_rand = 1'b1;
      err_addr = 32'h848;
      pool = '{32'h000, 32'h400, 32'h800, 32'h840, 32'h100, 32'h500, 32'hC40, 32'h040};
      pulse_flush();
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int          r, fa;
         a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3) * 4) +
             32'($urandom_range(0, 3));
         r  = int'($urandom_range(0, 9));
         fa = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 3)) : -1;
         if ($urandom_range(0, 9) == 0) pulse_flush();
         txn($sformatf("rnd%0d", i), a, fa, 1'b0, 32'h0, 1'b0, 0);
      end

      check("mreq.wen_never_set", 32'(wen_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter LINE_COUNT, default 64: number of direct-mapped lines; power of two.
REQ-002 Parameter WORDS_PER_LINE, default 4: 32-bit words per line; power of two.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 creq  inout  meminf::CacheReq  fetch request from inst_queue; fields valid, ready (driven here), addr[31:0], wen, wdata, wmask.
REQ-006 cresp  inout  meminf::CacheResp  fetch response to inst_queue; fields valid, rdata[31:0], error, errty (all driven here).
REQ-007 mreq  inout  meminf::CacheReq  refill read request to memory; valid, addr, wen driven here; ready driven by memory.
REQ-008 mresp  inout  meminf::CacheResp  refill data from memory; valid, rdata, error, errty.
REQ-009 flush  input  1  invalidate all lines (fence.i).

Function
REQ-010 Address split: offset = addr[log2(WORDS_PER_LINE)+1:2], index = next log2(LINE_COUNT) bits, tag = remaining upper bits; addr[1:0] ignored.
REQ-011 creq.wen, wdata, wmask are ignored; every accepted request is a read.
REQ-012 States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND.
REQ-013 creq.ready = 1 in IDLE, and in LOOKUP on a hit; 0 otherwise.
REQ-014 Request accepted when creq.valid & creq.ready; address latched; next state LOOKUP.
REQ-015 LOOKUP hit (line valid & tag equal): cresp.valid = 1 that cycle, rdata = stored word, error = 0; next state LOOKUP if a new request is accepted, else IDLE.
REQ-016 Hit latency: exactly 1 cycle after acceptance; back-to-back hits sustain one response per cycle.
REQ-017 LOOKUP miss: cresp.valid = 0; refill counter cleared; next state REFILL_REQ.
REQ-018 REFILL_REQ: mreq.valid = 1, mreq.wen = 0, mreq.addr = {tag, index, counter, 2'b00}; advance to REFILL_WAIT on mreq.ready.
REQ-019 REFILL_WAIT: on mresp.valid, write mresp.rdata into the line at counter; counter+1; next state REFILL_REQ until the last word, then RESPOND; one outstanding memory read at a time.
REQ-020 Refill order: word 0 to WORDS_PER_LINE-1 from the line base, no critical-word-first.
REQ-021 mresp.error on any refill word: remaining words still fetched; line not marked valid; error and errty of the first failing word held for the response.
REQ-022 RESPOND: cresp.valid = 1 for one cycle with the requested word, or error = 1, errty = held value, rdata = 0; on success set line valid and tag; next state IDLE.
REQ-023 cresp.valid is a single-cycle pulse with no back-pressure; the consumer discards unwanted responses; exactly one response per accepted request.
REQ-024 flush in IDLE/LOOKUP: all valid bits cleared at the clock edge; a LOOKUP in that same cycle uses pre-flush state.
REQ-025 flush during REFILL_REQ/REFILL_WAIT/RESPOND: all valid bits cleared; current refill completes and responds, but that line is not marked valid.
REQ-026 Outputs outside the listed conditions: mreq.valid = 0, cresp.valid = 0, cresp.error = 0.

Reset
REQ-027 rst_n low: state IDLE, all valid bits 0, counter 0, held error 0, cresp.valid 0, mreq.valid 0, creq.ready 1 once released; data and tag arrays not reset.
REQ-028 Reset mid-refill abandons it with no response; any late mresp.valid arriving in IDLE is ignored.

Structure
REQ-029 ICacheState enum and derived widths (OFFSET_W, INDEX_W, TAG_W) reside in package meminf.
REQ-030 Tag/valid/data storage is one sub-module, icache_array: one synchronous write port, asynchronous read by index.

Verification
REQ-031 Cold miss at 0x0000_0104, memory words 0x11,0x22,0x33,0x44 at 0x100..0x10C -> mreq.addr 0x100,0x104,0x108,0x10C in order; cresp.rdata 0x22, error 0.
REQ-032 After REQ-031, requests 0x100, 0x108, 0x10C back-to-back -> responses 0x11, 0x33, 0x44 on three consecutive cycles; no mreq.valid.
REQ-033 Request 0x0000_0500, memory errors word 1 with errty E -> cresp.error 1, errty E, rdata 0; repeat request 0x500 -> refill again.
REQ-034 flush after REQ-031, then request 0x104 -> full 4-word refill re-issued.
REQ-035 Conflict: 0x104 cached, request 0x0000_0504 (same index, different tag) -> refill, then 0x104 misses.
REQ-036 rst_n low during REFILL_WAIT word 2 -> no cresp.valid; request 0x104 after release -> refill from word 0.
